// File: rtl/state_seq_ctrl_if.sv
// rtl/state_seq_ctrl_if.sv - control/status bundle for the state sequencer (STATE_SEQ_FAULT_INJ_EN adds inject/fault_hit)
interface state_seq_ctrl_if #(
  parameter int CNT_W = 16
) ();
  logic             step;
  logic             use_ext;
  logic [1:0]       br_sel;
  logic             force_en;
  logic [3:0]       force_state;
  logic [3:0]       state;
  logic [3:0]       old_state;
  logic             step_done;
  logic             illegal;
  logic [CNT_W-1:0] loop_cnt;
`ifdef STATE_SEQ_FAULT_INJ_EN
  logic             inject;
  logic             fault_hit;

  modport master (
    output step, use_ext, br_sel, force_en, force_state, inject,
    input  state, old_state, step_done, illegal, loop_cnt, fault_hit
  );
  modport slave (
    input  step, use_ext, br_sel, force_en, force_state, inject,
    output state, old_state, step_done, illegal, loop_cnt, fault_hit
  );
`else
  modport master (
    output step, use_ext, br_sel, force_en, force_state,
    input  state, old_state, step_done, illegal, loop_cnt
  );
  modport slave (
    input  step, use_ext, br_sel, force_en, force_state,
    output state, old_state, step_done, illegal, loop_cnt
  );
`endif
endinterface

// File: rtl/state_seq_ctrl.sv
// rtl/state_seq_ctrl.sv - legal-graph state sequencer with LFSR/external branching (optional STATE_SEQ_FAULT_INJ_EN)
module state_seq_ctrl #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          CNT_W     = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  state_seq_ctrl_if.slave bus
);

  // A zero seed would lock the LFSR, so fall back to the default seed.
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;

  localparam logic [3:0] S0  = 4'd0;
  localparam logic [3:0] S1  = 4'd1;
  localparam logic [3:0] S2  = 4'd2;
  localparam logic [3:0] S3  = 4'd3;
  localparam logic [3:0] S4  = 4'd4;
  localparam logic [3:0] S5  = 4'd5;
  localparam logic [3:0] S6  = 4'd6;
  localparam logic [3:0] S7  = 4'd7;
  localparam logic [3:0] S8  = 4'd8;
  localparam logic [3:0] S9  = 4'd9;
  localparam logic [3:0] S14 = 4'd14;
  // Illegal codes re-enter the graph here.
  localparam logic [3:0] S_RECOVER = S4;

  logic [3:0]       r_state;
  logic [3:0]       r_old_state;
  logic             r_step_done;
  logic [CNT_W-1:0] r_loop_cnt;
  logic [15:0]      r_lfsr;

  logic [1:0]       w_c;
  logic [3:0]       w_next;
  logic [3:0]       w_step_state;
  logic             w_legal;
  logic             w_inject;
  logic             w_loop_hit;
  logic             w_lfsr_fb;
  logic             w_do_step;

  assign w_do_step = bus.step & ~bus.force_en;
  assign w_c       = bus.use_ext ? bus.br_sel : r_lfsr[1:0];
  assign w_legal   = (r_state <= S9) || (r_state == S14);
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

`ifdef STATE_SEQ_FAULT_INJ_EN
  logic r_fault_hit;
  assign w_inject      = bus.inject;
  assign bus.fault_hit = r_fault_hit;

  // One-cycle pulse whenever a step was deliberately corrupted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fault_hit <= 1'b0;
    else        r_fault_hit <= w_do_step & bus.inject;
  end
`else
  assign w_inject = 1'b0;
`endif

  // Next state of the legal graph for the current branch choice.
  always_comb begin
    w_next = S_RECOVER;
    case (r_state)
      S0:  w_next = S1;
      S1:  w_next = w_c[0] ? S4 : S2;
      S2:  w_next = S3;
      S3:  w_next = w_c[0] ? S5 : S1;
      S4:  w_next = S5;
      S5:  w_next = w_c[0] ? S6 : S1;
      S6:  w_next = S7;
      S7:  w_next = w_c[0] ? S8 : S0;
      S8: begin
        case (w_c)
          2'b00:   w_next = S2;
          2'b01:   w_next = S4;
          2'b10:   w_next = S14;
          default: w_next = S9;
        endcase
      end
      S9:      w_next = S0;
      S14:     w_next = S0;
      default: w_next = S_RECOVER;
    endcase
  end

  // A faulted step lands one code past the legal successor.
  assign w_step_state = w_next + {3'b000, w_inject};

  // Only genuine loop closures count; recovery goes to 4 so never matches.
  assign w_loop_hit = ((r_state == S7) || (r_state == S9) || (r_state == S14)) &&
                      (w_next == S0) && !w_inject;

  // State/old_state registers: force beats step, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S0;
      r_old_state <= S0;
      r_step_done <= 1'b0;
    end else if (bus.force_en) begin
      r_old_state <= r_state;
      r_state     <= bus.force_state;
      r_step_done <= 1'b0;
    end else if (bus.step) begin
      r_old_state <= r_state;
      r_state     <= w_step_state;
      r_step_done <= 1'b1;
    end else begin
      r_step_done <= 1'b0;
    end
  end

  // Branch LFSR advances only when it actually supplied the branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_lfsr <= SEED;
    else if (w_do_step && !bus.use_ext) r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
  end

  // Saturating count of completed loops back to state 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_loop_cnt <= '0;
    else if (w_do_step && w_loop_hit && (r_loop_cnt != {CNT_W{1'b1}}))
      r_loop_cnt <= r_loop_cnt + 1'b1;
  end

  assign bus.state     = r_state;
  assign bus.old_state = r_old_state;
  assign bus.step_done = r_step_done;
  assign bus.illegal   = ~w_legal;
  assign bus.loop_cnt  = r_loop_cnt;

endmodule
